// File: rtl/absolute_value_pipe.sv
// absolute_value_pipe: 2-stage valid/ready |x| unit with sign, overflow flag and clearable peak.
// Define ABS_SATURATE_EN to clamp |-2^(N-1)| to 2^(N-1)-1 instead of wrapping.
module absolute_value_pipe #(
  parameter int N = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_abs,
  output logic         out_neg,
  output logic         out_ovf,
  output logic [N-1:0] peak,
  input  logic         peak_clr
);
  logic         v1, s1, ovf, adv, xfer;
  logic [N-1:0] x1, mag;
  always_comb begin
    adv = !out_valid || out_ready;
    in_ready = adv;
    xfer = out_valid && out_ready;
    ovf = x1 == {1'b1, {(N-1){1'b0}}};
`ifdef ABS_SATURATE_EN
    mag = ovf ? {1'b0, {(N-1){1'b1}}} : s1 ? -x1 : x1;
`else
    mag = s1 ? -x1 : x1;
`endif
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      v1 <= 1'b0;
      s1 <= 1'b0;
      x1 <= '0;
      out_valid <= 1'b0;
      out_abs <= '0;
      out_neg <= 1'b0;
      out_ovf <= 1'b0;
      peak <= '0;
    end else begin
      if (adv) begin
        v1 <= in_valid;
        x1 <= in_data;
        s1 <= in_data[N-1];
        out_valid <= v1;
        out_abs <= mag;
        out_neg <= s1;
        out_ovf <= ovf;
      end
      // a clear coinciding with a delivery restarts the peak from that sample
      if (xfer) peak <= (peak_clr || out_abs > peak) ? out_abs : peak;
      else if (peak_clr) peak <= '0;
    end
  end
endmodule

// File: tb/tb_absolute_value_pipe.sv
// tb_absolute_value_pipe: scoreboard bench for absolute_value_pipe (N=8 plus an N=16 spot check).
module tb_absolute_value_pipe;
  typedef struct {
    logic [7:0] a;
    logic       n;
    logic       o;
  } exp_t;

  logic        clock = 0, reset = 1, in_valid = 0, out_ready = 1, peak_clr = 0;
  logic [7:0]  in_data = 0;
  logic        in_ready, out_valid, out_neg, out_ovf;
  logic [7:0]  out_abs, peak;
  logic        v16 = 0, r16, ov16, on16, oo16;
  logic [15:0] d16 = 0, a16, p16;
  int          checks = 0, errors = 0, rmode = 0, pidx = 0;
  exp_t        q[$];
  logic [7:0]  peak_m = 0;
  logic        prev_stall = 0, prev_n = 0, prev_o = 0;
  logic [7:0]  prev_a = 0;

  absolute_value_pipe #(.N(8)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_abs(out_abs), .out_neg(out_neg), .out_ovf(out_ovf),
    .peak(peak), .peak_clr(peak_clr)
  );

  absolute_value_pipe #(.N(16)) dut16 (
    .clock(clock), .reset(reset), .in_valid(v16), .in_ready(r16),
    .in_data(d16), .out_valid(ov16), .out_ready(1'b1),
    .out_abs(a16), .out_neg(on16), .out_ovf(oo16),
    .peak(p16), .peak_clr(1'b0)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // reference: absolute value by integer arithmetic on the signed sample
  function automatic exp_t model(input logic [7:0] d);
    exp_t e;
    int v, a;
    v = int'($signed(d));
    a = v < 0 ? -v : v;
    e.n = v < 0;
    e.o = v == -128;
`ifdef ABS_SATURATE_EN
    if (a > 127) a = 127;
`endif
    e.a = a[7:0];
    return e;
  endfunction

  always @(posedge clock) begin
    #1;
    if (rmode == 1) begin
      out_ready = (pidx % 4 == 0) || (pidx % 4 == 3);
      pidx++;
    end else if (rmode == 2) out_ready = 1'($urandom_range(0, 1));
  end

  always @(negedge clock)
    if (!reset && in_valid && in_ready) q.push_back(model(in_data));

  always @(negedge clock) begin
    exp_t e;
    if (reset) begin
      q.delete();
      peak_m = 0;
      prev_stall = 0;
    end else begin
      chk("in_ready", 32'(in_ready), 32'(!out_valid || out_ready));
      chk("peak", 32'(peak), 32'(peak_m));
      if (prev_stall) begin
        chk("stall_valid", 32'(out_valid), 1);
        chk("stall_abs", 32'(out_abs), 32'(prev_a));
        chk("stall_neg", 32'(out_neg), 32'(prev_n));
        chk("stall_ovf", 32'(out_ovf), 32'(prev_o));
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got abs %0h with nothing pending", out_abs);
        end else begin
          e = q.pop_front();
          chk("out_abs", 32'(out_abs), 32'(e.a));
          chk("out_neg", 32'(out_neg), 32'(e.n));
          chk("out_ovf", 32'(out_ovf), 32'(e.o));
          peak_m = (peak_clr || e.a > peak_m) ? e.a : peak_m;
        end
      end else if (peak_clr) peak_m = 0;
      prev_stall = out_valid && !out_ready;
      prev_a = out_abs;
      prev_n = out_neg;
      prev_o = out_ovf;
    end
  end

  task automatic send(input int v);
    logic acc;
    int n = 0;
    in_valid = 1;
    in_data = v[7:0];
    do begin
      @(negedge clock) acc = in_ready;
      @(posedge clock) #1;
      n++;
    end while (!acc && n < 100);
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got no accept expected accept within 100 cycles");
    end
    in_valid = 0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || out_valid) && n < 200) begin
      @(posedge clock) #1;
      n++;
    end
    chk("drain", 32'(q.size()), 0);
  endtask

  task automatic clr_pulse();
    @(posedge clock) #1 peak_clr = 1;
    @(posedge clock) #1 peak_clr = 0;
  endtask

  initial begin
    int pick, n;
    repeat (3) @(posedge clock);
    #1 reset = 0;
    @(negedge clock);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_abs", 32'(out_abs), 0);
    chk("rst_neg", 32'(out_neg), 0);
    chk("rst_ovf", 32'(out_ovf), 0);
    chk("rst_peak", 32'(peak), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    // stream 5,-5,0,127 back to back and time the first result
    @(posedge clock) #1 in_valid = 1;
    in_data = 8'd5;
    @(posedge clock) #1 in_data = 8'hFB;
    @(negedge clock) chk("latency_early", 32'(out_valid), 0);
    @(posedge clock) #1 in_data = 8'd0;
    @(negedge clock) chk("latency", 32'(out_valid), 1);
    chk("first_abs", 32'(out_abs), 5);
    @(posedge clock) #1 in_data = 8'd127;
    @(posedge clock) #1 in_valid = 0;
    drain();
    send(-128);
    drain();
`ifdef ABS_SATURATE_EN
    chk("peak_min", 32'(peak), 127);
`else
    chk("peak_min", 32'(peak), 128);
`endif
    rmode = 1;
    send(-3); send(-7); send(2); send(-9);
    drain();
    rmode = 0;
    out_ready = 1;
    clr_pulse();
    send(4); send(-20); send(10);
    drain();
    @(negedge clock) chk("peak_20", 32'(peak), 20);
    @(posedge clock) #1;
    clr_pulse();
    @(negedge clock) chk("peak_clr", 32'(peak), 0);
    @(posedge clock) #1 in_valid = 1;
    in_data = 8'hFA;
    @(posedge clock) #1 in_valid = 0;
    @(posedge clock) #1 peak_clr = 1;
    @(posedge clock) #1 peak_clr = 0;
    @(negedge clock) chk("peak_clr_xfer", 32'(peak), 6);
    // reset with two samples in flight
    @(posedge clock) #1 out_ready = 0;
    in_valid = 1;
    in_data = 8'd33;
    @(posedge clock) #1 in_data = 8'hD4;
    @(posedge clock) #1 in_valid = 0;
    reset = 1;
    @(posedge clock) #1 reset = 0;
    out_ready = 1;
    @(negedge clock);
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_peak", 32'(peak), 0);
    @(posedge clock) #1;
    send(9);
    drain();
    // N=16 spot check
    v16 = 1;
    d16 = 16'h8001;
    @(posedge clock) #1 v16 = 0;
    n = 0;
    while (!ov16 && n < 10) begin
      @(negedge clock);
      n++;
    end
    chk("n16_valid", 32'(ov16), 1);
    chk("n16_abs", 32'(a16), 32767);
    chk("n16_neg", 32'(on16), 1);
    chk("n16_ovf", 32'(oo16), 0);
    @(posedge clock) #1 rmode = 2;
    repeat (400) begin
      pick = $urandom_range(0, 7);
      in_valid = 1'($urandom_range(0, 1));
      in_data = pick == 0 ? 8'h80 : pick == 1 ? 8'h7F : pick == 2 ? 8'h00 :
                pick == 3 ? 8'h81 : 8'($urandom);
      peak_clr = $urandom_range(0, 9) == 0;
      @(posedge clock) #1;
    end
    in_valid = 0;
    peak_clr = 0;
    rmode = 0;
    out_ready = 1;
    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
